// File: rtl/uartb_tx_arbiter.sv
// Arbitrates NREQ requesters onto one UARTB_CORE transmitter, reprogramming the core mode on demand.
// Define UARTB_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module uartb_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DIVIDER = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_mode,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          uart_d,
  output logic                 uart_wrtx,
  output logic                 uart_wrbaud,
  input  logic                 uart_thre,
  input  logic                 uart_tend,
  output logic                 cur_mode,
  output logic [2:0]           grant_id,
  output logic                 busy
);

  localparam logic [8:0] DIV9 = DIVIDER[8:0];

  typedef enum logic [3:0] {
    S_CFG0, S_IDLE, S_DRAIN, S_CFG, S_SETTLE, S_WAITTX, S_WRITE, S_HOLD1, S_HOLD2
  } state_e;

  state_e            state_q;
  logic [31:0]       d_q;
  logic              wrtx_q, wrbaud_q, mode_q, busy_q;
  logic [2:0]        grant_q;
  logic [NREQ-1:0]   ack_q;

  logic              pick_valid, pick_mode;
  logic [2:0]        pick_id;
  logic [NREQ-1:0]   grant_oh;
  logic              g_req, g_mode;
  logic [31:0]       g_data;
  logic [2:0]        grant_next;

  // Decode of the latched winner, so the requester arrays are never indexed past NREQ.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    grant_oh = '0;
    g_data   = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_oh[i] = (grant_q == 3'(i));
      if (grant_oh[i]) g_data = g_data | req_data[32*i +: 32];
    end
    g_req  = |(req & grant_oh);
    g_mode = |(req_mode & grant_oh);
  end

  assign grant_next = (grant_q == 3'(NREQ-1)) ? 3'd0 : grant_q + 3'd1;

`ifdef UARTB_ARB_FIXED_PRIO_EN
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    pick_mode  = 1'b0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req[i]) begin
        pick_valid = 1'b1;
        pick_id    = 3'(i);
        pick_mode  = req_mode[i];
      end
    end
  end
`else
  logic [2:0] rr_ptr_q;

  // Scan downward so the candidate nearest rr_ptr is written last and wins.
  always_comb begin
    int idx;
    pick_valid = 1'b0;
    pick_id    = '0;
    pick_mode  = 1'b0;
    idx        = 0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = 3'(idx);
        pick_mode  = req_mode[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  rr_ptr_q <= '0;
    else if (state_q == S_WRITE) rr_ptr_q <= grant_next;
  end
`endif

  // Strobes are registered on leaving a state, so each is visible for exactly the following cycle.
  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_CFG0;
      d_q      <= '0;
      wrtx_q   <= 1'b0;
      wrbaud_q <= 1'b0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      grant_q  <= '0;
      ack_q    <= '0;
    end else begin
      wrtx_q   <= 1'b0;
      wrbaud_q <= 1'b0;
      ack_q    <= '0;
      case (state_q)
        S_CFG0: begin
          wrbaud_q <= 1'b1;
          d_q      <= {1'b0, 22'b0, DIV9};
          mode_q   <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        S_IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_id;
            busy_q  <= 1'b1;
            state_q <= (pick_mode == mode_q) ? S_WAITTX : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (uart_thre && uart_tend) state_q <= S_CFG;
        end
        S_CFG: begin
          wrbaud_q <= 1'b1;
          d_q      <= {g_mode, 22'b0, DIV9};
          mode_q   <= g_mode;
          state_q  <= S_SETTLE;
        end
        S_SETTLE: state_q <= S_WAITTX;
        S_WAITTX: begin
          if (!g_req) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (uart_thre) begin
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          wrtx_q  <= 1'b1;
          ack_q   <= grant_oh;
          d_q     <= mode_q ? g_data : {24'b0, g_data[7:0]};
          state_q <= S_HOLD1;
        end
        S_HOLD1: state_q <= S_HOLD2;
        S_HOLD2: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign uart_d      = d_q;
  assign uart_wrtx   = wrtx_q;
  assign uart_wrbaud = wrbaud_q;
  assign cur_mode    = mode_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign ack         = ack_q;

endmodule

// File: tb/tb_uartb_tx_arbiter.sv
// Directed self-checking bench for uartb_tx_arbiter (NREQ=4, DIVIDER=7); inputs change and outputs
// are sampled on the falling edge.
module tb_uartb_tx_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req, req_mode, ack;
  logic [127:0] req_data;
  logic [31:0]  uart_d;
  logic         uart_wrtx, uart_wrbaud, uart_thre, uart_tend, cur_mode, busy;
  logic [2:0]   grant_id;

  int n_cmp = 0;
  int n_bad = 0;

  uartb_tx_arbiter #(.NREQ(4), .DIVIDER(7)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_mode(req_mode), .req_data(req_data),
    .ack(ack), .uart_d(uart_d), .uart_wrtx(uart_wrtx), .uart_wrbaud(uart_wrbaud),
    .uart_thre(uart_thre), .uart_tend(uart_tend), .cur_mode(cur_mode),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Strobes never overlap, and an ack only ever accompanies a TX write.
  always @(negedge clk) begin
    if (rst_n === 1'b1)
      check("strobe_rules", {31'b0, (uart_wrtx & uart_wrbaud) | ((|ack) & ~uart_wrtx)}, 32'h0);
  end

  initial begin
    logic [3:0] exp_ack;
    logic [3:0] last_ack;
    rst_n = 1'b0; req = '0; req_mode = '0; req_data = '0; uart_thre = 1'b0; uart_tend = 1'b0;
    repeat (2) tick();
    check("rst_wrbaud", {31'b0, uart_wrbaud}, 32'h0);
    check("rst_d", uart_d, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);

    // Reset release: CFG0 writes the divider in normal mode.
    rst_n = 1'b1;
    tick();
    check("t1_wrbaud", {31'b0, uart_wrbaud}, 32'h1);
    check("t1_d", uart_d, 32'h00000007);
    check("t1_mode", {31'b0, cur_mode}, 32'h0);
    tick();
    check("t1_busy", {31'b0, busy}, 32'h0);
    check("t1_wrbaud_off", {31'b0, uart_wrbaud}, 32'h0);

    // Normal-mode byte from requester 0.
    uart_thre = 1'b1; uart_tend = 1'b1;
    req = 4'b0001; req_mode = 4'b0000; req_data[31:0] = 32'h00000041;
    tick();
    check("t2_grant", {29'b0, grant_id}, 32'h0);
    check("t2_busy", {31'b0, busy}, 32'h1);
    tick(); tick();
    check("t2_wrtx", {31'b0, uart_wrtx}, 32'h1);
    check("t2_ack", {28'b0, ack}, 32'h1);
    check("t2_d", uart_d, 32'h00000041);
    check("t2_no_wrbaud", {31'b0, uart_wrbaud}, 32'h0);
    req = 4'b0000;
    tick();
    check("t2_d_hold", uart_d, 32'h00000041);
    tick();
    check("t2_idle", {31'b0, busy}, 32'h0);

    // Burst request from requester 1 must wait for the line to go idle.
    uart_tend = 1'b0;
    req = 4'b0010; req_mode = 4'b0010; req_data[63:32] = 32'h44434241;
    tick();
    check("t3_grant", {29'b0, grant_id}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_drain_quiet", {30'b0, uart_wrbaud, uart_wrtx}, 32'h0);
    end
    uart_tend = 1'b1;
    tick(); tick();
    check("t3_wrbaud", {31'b0, uart_wrbaud}, 32'h1);
    check("t3_cfg_d", uart_d, 32'h80000007);
    check("t3_mode", {31'b0, cur_mode}, 32'h1);
    tick();
    check("t3_settle_quiet", {30'b0, uart_wrbaud, uart_wrtx}, 32'h0);
    tick(); tick();
    check("t3_wrtx", {31'b0, uart_wrtx}, 32'h1);
    check("t3_d", uart_d, 32'h44434241);
    check("t3_ack", {28'b0, ack}, 32'h2);
    req = 4'b0000;
    tick(); tick();
    check("t3_idle", {31'b0, busy}, 32'h0);

    // Fresh reset so the round-robin pointer starts at 0, then four held requests.
    rst_n = 1'b0;
    #1;
    check("t4_rst_mode", {31'b0, cur_mode}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t4_cfg0_d", uart_d, 32'h00000007);
    req_mode = 4'b0000;
    req_data = {32'hA5A5A533, 32'hA5A5A532, 32'hA5A5A531, 32'hA5A5A530};
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      repeat ((g == 0) ? 3 : 5) tick();
`ifdef UARTB_ARB_FIXED_PRIO_EN
      exp_ack = 4'b0001;
`else
      exp_ack = 4'b0001 << (g % 4);
`endif
      check("t4_wrtx", {31'b0, uart_wrtx}, 32'h1);
      check("t4_ack", {28'b0, ack}, {28'b0, exp_ack});
      check("t4_d", uart_d, 32'h30 + ((exp_ack == 4'b0001) ? 0 : (exp_ack == 4'b0010) ? 1 :
                                      (exp_ack == 4'b0100) ? 2 : 3));
    end
    req = 4'b0000;
    tick(); tick();
    check("t4_idle", {31'b0, busy}, 32'h0);

    // Requester 2 withdraws while the holding register is full: grant abandoned.
    uart_thre = 1'b0;
    req = 4'b0100;
    tick();
    check("t5_grant", {29'b0, grant_id}, 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_wait_quiet", {27'b0, ack, uart_wrtx}, 32'h0);
    end
    req = 4'b0000;
    tick();
    check("t5_idle", {31'b0, busy}, 32'h0);
    check("t5_no_ack", {27'b0, ack, uart_wrtx}, 32'h0);
    // The abandoned grant must not have advanced the pointer (still at 1).
    uart_thre = 1'b1;
    req = 4'b0101;
    tick(); tick(); tick();
`ifdef UARTB_ARB_FIXED_PRIO_EN
    last_ack = 4'b0001;
`else
    last_ack = 4'b0100;
`endif
    check("t5_next_ack", {28'b0, ack}, {28'b0, last_ack});
    req = 4'b0000;
    tick(); tick();

    // Reset arrives the cycle after the mode write: everything clears, CFG0 repeats.
    req = 4'b0001; req_mode = 4'b0001;
    tick(); tick(); tick();
    check("t6_wrbaud", {31'b0, uart_wrbaud}, 32'h1);
    check("t6_cfg_d", uart_d, 32'h80000007);
    rst_n = 1'b0;
    #1;
    check("t6_async_d", uart_d, 32'h0);
    check("t6_async_strobes", {26'b0, ack, uart_wrtx, uart_wrbaud}, 32'h0);
    check("t6_async_state", {27'b0, cur_mode, busy, grant_id}, 32'h0);
    req = 4'b0000; req_mode = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_cfg0_wrbaud", {31'b0, uart_wrbaud}, 32'h1);
    check("t6_cfg0_d", uart_d, 32'h00000007);
    check("t6_cfg0_mode", {31'b0, cur_mode}, 32'h0);
    tick();
    check("t6_quiet", {26'b0, ack, uart_wrtx, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
